// File: rtl/retire_multi.sv
// rtl/retire_multi.sv - N-wide in-order retire stage with completion buffer and store handshake; optional bypass under RETIRE_FWD_EN
module retire_multi #(
  parameter int ROB_SZ       = 32,
  parameter int CP_PORTS     = 2,
  parameter int RETIRE_WIDTH = 2,
  parameter int XLEN         = 32,
  parameter int PREG_W       = 6,
  parameter int IDX_W        = $clog2(ROB_SZ),
  localparam int CNT_W       = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [CP_PORTS-1:0]            cp_valid,
  input  logic [CP_PORTS*IDX_W-1:0]      cp_rob_idx,
  input  logic [CP_PORTS*XLEN-1:0]       cp_result,
  input  logic [CP_PORTS*XLEN-1:0]       cp_rs2_value,
  input  logic [CP_PORTS-1:0]            cp_is_store,
  input  logic [CP_PORTS-1:0]            cp_regfile_en,
  input  logic [CP_PORTS*PREG_W-1:0]     cp_regfile_idx,
  input  logic [CP_PORTS*XLEN-1:0]       cp_npc,
  input  logic [CP_PORTS*4-1:0]          cp_error,
  input  logic [IDX_W-1:0]               rob_head,
  input  logic                           clear_retire_buffer,
  output logic [CNT_W-1:0]               retire_count,
  output logic                           store_req,
  input  logic                           store_ready,
  output logic [XLEN-1:0]                store_addr,
  output logic [XLEN-1:0]                store_data,
  output logic [RETIRE_WIDTH-1:0]        commit_valid,
  output logic [RETIRE_WIDTH-1:0]        commit_wr_en,
  output logic [RETIRE_WIDTH*PREG_W-1:0] commit_wr_idx,
  output logic [RETIRE_WIDTH*XLEN-1:0]   commit_wr_data,
  output logic [RETIRE_WIDTH*XLEN-1:0]   commit_npc,
  output logic [3:0]                     pipeline_completed_insts,
  output logic [3:0]                     pipeline_error_status,
  output logic                           halted,
  output logic                           dup_error
);

  localparam logic [3:0] NO_ERROR = 4'hA;

  // completion buffer, one entry per ROB slot
  logic [ROB_SZ-1:0] buf_valid;
  logic [ROB_SZ-1:0] buf_store;
  logic [ROB_SZ-1:0] buf_wen;
  logic [PREG_W-1:0] buf_widx [ROB_SZ];
  logic [XLEN-1:0]   buf_res  [ROB_SZ];
  logic [XLEN-1:0]   buf_rs2  [ROB_SZ];
  logic [XLEN-1:0]   buf_npc  [ROB_SZ];
  logic [3:0]        buf_err  [ROB_SZ];

  // per-lane view of the retire window
  logic [IDX_W-1:0]        ln_slot [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0] ln_valid;
  logic [RETIRE_WIDTH-1:0] ln_store;
  logic [RETIRE_WIDTH-1:0] ln_wen;
  logic [PREG_W-1:0]       ln_widx [RETIRE_WIDTH];
  logic [XLEN-1:0]         ln_res  [RETIRE_WIDTH];
  logic [XLEN-1:0]         ln_rs2  [RETIRE_WIDTH];
  logic [XLEN-1:0]         ln_npc  [RETIRE_WIDTH];
  logic [3:0]              ln_err  [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0] ln_commit;
`ifdef RETIRE_FWD_EN
  logic [RETIRE_WIDTH-1:0] ln_byp;
`endif

  logic [ROB_SZ-1:0]   ret_mask;
  logic [CP_PORTS-1:0] wr_ok;
  logic                dup_now;
  logic                go;
  logic                store_seen;

  // gather each lane's entry from the buffer (or a same-cycle completion when bypass is built)
  always_comb begin
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      ln_slot[k]  = rob_head + IDX_W'(k);
      ln_valid[k] = buf_valid[rob_head + IDX_W'(k)];
      ln_store[k] = buf_store[rob_head + IDX_W'(k)];
      ln_wen[k]   = buf_wen[rob_head + IDX_W'(k)];
      ln_widx[k]  = buf_widx[rob_head + IDX_W'(k)];
      ln_res[k]   = buf_res[rob_head + IDX_W'(k)];
      ln_rs2[k]   = buf_rs2[rob_head + IDX_W'(k)];
      ln_npc[k]   = buf_npc[rob_head + IDX_W'(k)];
      ln_err[k]   = buf_err[rob_head + IDX_W'(k)];
`ifdef RETIRE_FWD_EN
      ln_byp[k] = 1'b0;
      // descending scan so the lowest-numbered port ends up supplying the lane
      for (int p = CP_PORTS - 1; p >= 0; p--) begin
        if (!clear_retire_buffer && cp_valid[p] &&
            cp_rob_idx[p*IDX_W +: IDX_W] == rob_head + IDX_W'(k)) begin
          ln_byp[k]   = 1'b1;
          ln_valid[k] = 1'b1;
          ln_store[k] = cp_is_store[p];
          ln_wen[k]   = cp_regfile_en[p];
          ln_widx[k]  = cp_regfile_idx[p*PREG_W +: PREG_W];
          ln_res[k]   = cp_result[p*XLEN +: XLEN];
          ln_rs2[k]   = cp_rs2_value[p*XLEN +: XLEN];
          ln_npc[k]   = cp_npc[p*XLEN +: XLEN];
          ln_err[k]   = cp_error[p*4 +: 4];
        end
      end
`endif
    end
  end

  // walk lanes in order; stop at a hole, a second store, an unaccepted store or after an error
  always_comb begin
    ln_commit  = '0;
    store_req  = 1'b0;
    store_addr = '0;
    store_data = '0;
    go         = !halted && !clear_retire_buffer;
    store_seen = 1'b0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (go) begin
        if (!ln_valid[k]) begin
          go = 1'b0;
        end else if (ln_store[k] && store_seen) begin
          go = 1'b0;
        end else begin
          if (ln_store[k]) begin
            store_seen = 1'b1;
            store_req  = 1'b1;
            store_addr = ln_res[k];
            store_data = ln_rs2[k];
            if (!store_ready) go = 1'b0;
          end
          if (go) begin
            ln_commit[k] = 1'b1;
            if (ln_err[k] != NO_ERROR) go = 1'b0;
          end
        end
      end
    end
  end

  // committed lanes are a contiguous prefix, so a population count is the retire count
  always_comb begin
    retire_count = '0;
    ret_mask     = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (ln_commit[k]) begin
        retire_count         = retire_count + CNT_W'(1);
        ret_mask[ln_slot[k]] = 1'b1;
      end
    end
  end

  // decide which completions land in the buffer and flag duplicate writes
  always_comb begin
    wr_ok   = '0;
    dup_now = 1'b0;
    if (!clear_retire_buffer) begin
      for (int p = 0; p < CP_PORTS; p++) begin
        if (cp_valid[p]) begin
          wr_ok[p] = 1'b1;
          for (int q = 0; q < p; q++) begin
            if (cp_valid[q] && cp_rob_idx[q*IDX_W +: IDX_W] == cp_rob_idx[p*IDX_W +: IDX_W]) begin
              wr_ok[p] = 1'b0;
              dup_now  = 1'b1;
            end
          end
          if (buf_valid[cp_rob_idx[p*IDX_W +: IDX_W]] && !ret_mask[cp_rob_idx[p*IDX_W +: IDX_W]])
            dup_now = 1'b1;
`ifdef RETIRE_FWD_EN
          for (int k = 0; k < RETIRE_WIDTH; k++) begin
            if (ln_commit[k] && ln_byp[k] && ln_slot[k] == cp_rob_idx[p*IDX_W +: IDX_W])
              wr_ok[p] = 1'b0;
          end
`endif
        end
      end
    end
  end

  // slot valid bits: flush clears all, commits clear, completions set
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid <= '0;
    end else if (clear_retire_buffer) begin
      buf_valid <= '0;
    end else begin
      for (int k = 0; k < RETIRE_WIDTH; k++)
        if (ln_commit[k]) buf_valid[ln_slot[k]] <= 1'b0;
      for (int p = 0; p < CP_PORTS; p++)
        if (wr_ok[p]) buf_valid[cp_rob_idx[p*IDX_W +: IDX_W]] <= 1'b1;
    end
  end

  // entry payload; only meaningful while the valid bit is set, so it needs no reset
  always_ff @(posedge clock) begin
    for (int p = 0; p < CP_PORTS; p++) begin
      if (wr_ok[p]) begin
        buf_store[cp_rob_idx[p*IDX_W +: IDX_W]] <= cp_is_store[p];
        buf_wen[cp_rob_idx[p*IDX_W +: IDX_W]]   <= cp_regfile_en[p];
        buf_widx[cp_rob_idx[p*IDX_W +: IDX_W]]  <= cp_regfile_idx[p*PREG_W +: PREG_W];
        buf_res[cp_rob_idx[p*IDX_W +: IDX_W]]   <= cp_result[p*XLEN +: XLEN];
        buf_rs2[cp_rob_idx[p*IDX_W +: IDX_W]]   <= cp_rs2_value[p*XLEN +: XLEN];
        buf_npc[cp_rob_idx[p*IDX_W +: IDX_W]]   <= cp_npc[p*XLEN +: XLEN];
        buf_err[cp_rob_idx[p*IDX_W +: IDX_W]]   <= cp_error[p*4 +: 4];
      end
    end
  end

  // registered commit lanes, instruction count and sticky status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      commit_valid             <= '0;
      commit_wr_en             <= '0;
      commit_wr_idx            <= '0;
      commit_wr_data           <= '0;
      commit_npc               <= '0;
      pipeline_completed_insts <= '0;
      pipeline_error_status    <= NO_ERROR;
      halted                   <= 1'b0;
      dup_error                <= 1'b0;
    end else begin
      pipeline_completed_insts <= 4'(retire_count);
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        commit_valid[k]                   <= ln_commit[k];
        commit_wr_en[k]                   <= ln_commit[k] & ln_wen[k];
        commit_wr_idx[k*PREG_W +: PREG_W] <= ln_commit[k] ? ln_widx[k] : '0;
        commit_wr_data[k*XLEN +: XLEN]    <= ln_commit[k] ? ln_res[k] : '0;
        commit_npc[k*XLEN +: XLEN]        <= ln_commit[k] ? ln_npc[k] : '0;
        if (ln_commit[k] && ln_err[k] != NO_ERROR) begin
          halted                <= 1'b1;
          pipeline_error_status <= ln_err[k];
        end
      end
      if (dup_now) dup_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_retire_multi.sv
// tb/tb_retire_multi.sv - randomized and directed bench for retire_multi against a slot-array reference model
module tb_retire_multi;

  localparam int ROB = 32;
  localparam int CP  = 2;
  localparam int RW  = 2;
  localparam logic [3:0] NOERR = 4'hA;
  localparam logic [3:0] ILL   = 4'h2;
  localparam logic [3:0] WFI   = 4'hE;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [CP-1:0] cp_valid = '0;
  logic [CP*5-1:0]  cp_rob_idx = '0;
  logic [CP*32-1:0] cp_result = '0;
  logic [CP*32-1:0] cp_rs2_value = '0;
  logic [CP-1:0]    cp_is_store = '0;
  logic [CP-1:0]    cp_regfile_en = '0;
  logic [CP*6-1:0]  cp_regfile_idx = '0;
  logic [CP*32-1:0] cp_npc = '0;
  logic [CP*4-1:0]  cp_error = {CP{NOERR}};
  logic [4:0]    rob_head = '0;
  logic          clear_retire_buffer = 1'b0;
  logic [1:0]    retire_count;
  logic          store_req;
  logic          store_ready = 1'b1;
  logic [31:0]   store_addr, store_data;
  logic [RW-1:0] commit_valid, commit_wr_en;
  logic [RW*6-1:0]  commit_wr_idx;
  logic [RW*32-1:0] commit_wr_data, commit_npc;
  logic [3:0]    pipeline_completed_insts, pipeline_error_status;
  logic          halted, dup_error;

  retire_multi dut (
    .clock(clock), .reset_n(reset_n),
    .cp_valid(cp_valid), .cp_rob_idx(cp_rob_idx), .cp_result(cp_result),
    .cp_rs2_value(cp_rs2_value), .cp_is_store(cp_is_store), .cp_regfile_en(cp_regfile_en),
    .cp_regfile_idx(cp_regfile_idx), .cp_npc(cp_npc), .cp_error(cp_error),
    .rob_head(rob_head), .clear_retire_buffer(clear_retire_buffer),
    .retire_count(retire_count), .store_req(store_req), .store_ready(store_ready),
    .store_addr(store_addr), .store_data(store_data),
    .commit_valid(commit_valid), .commit_wr_en(commit_wr_en), .commit_wr_idx(commit_wr_idx),
    .commit_wr_data(commit_wr_data), .commit_npc(commit_npc),
    .pipeline_completed_insts(pipeline_completed_insts),
    .pipeline_error_status(pipeline_error_status),
    .halted(halted), .dup_error(dup_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: one record per ROB slot plus the sticky status
  bit         m_v   [ROB];
  bit         m_st  [ROB];
  bit         m_we  [ROB];
  logic [5:0] m_wi  [ROB];
  logic [31:0] m_res[ROB];
  logic [31:0] m_rs2[ROB];
  logic [31:0] m_npc[ROB];
  logic [3:0] m_err [ROB];
  bit         m_halt, m_dup;
  logic [3:0] m_stat;
  int         m_pci;
  bit         e_cv [RW];
  bit         e_we [RW];
  logic [5:0] e_wi [RW];
  logic [31:0] e_wd[RW];
  logic [31:0] e_np[RW];

  int         obs_rc;
  bit         obs_req;
  logic [31:0] obs_addr, obs_data;

  task automatic model_reset();
    for (int i = 0; i < ROB; i++) m_v[i] = 0;
    m_halt = 0; m_dup = 0; m_stat = NOERR; m_pci = 0;
  endtask

  task automatic put(input int p, input logic [4:0] idx, input logic [31:0] res,
                     input logic [31:0] rs2, input bit st, input bit we,
                     input logic [5:0] wi, input logic [31:0] npc, input logic [3:0] err);
    cp_valid[p]             = 1'b1;
    cp_rob_idx[p*5 +: 5]    = idx;
    cp_result[p*32 +: 32]   = res;
    cp_rs2_value[p*32 +: 32] = rs2;
    cp_is_store[p]          = st;
    cp_regfile_en[p]        = we;
    cp_regfile_idx[p*6 +: 6] = wi;
    cp_npc[p*32 +: 32]      = npc;
    cp_error[p*4 +: 4]      = err;
  endtask

  task automatic idle();
    cp_valid = '0;
  endtask

  // one clock: check combinational outputs at negedge, advance model, check registered outputs
  task automatic step();
    int n, s, stores, idx;
    bit sreq;
    logic [31:0] sa, sd;
    int sl [RW];
    bit retm [ROB];
    bit dupn, hit;
    @(negedge clock);
    n = 0; sreq = 0; sa = 0; sd = 0; stores = 0; dupn = 0;
    for (int i = 0; i < ROB; i++) retm[i] = 0;
    for (int k = 0; k < RW; k++) sl[k] = (int'(rob_head) + k) % ROB;
    if (!m_halt && !clear_retire_buffer) begin
      for (int k = 0; k < RW; k++) begin
        s = sl[k];
        if (!m_v[s]) break;
        if (m_st[s]) begin
          if (stores > 0) break;
          stores++;
          sreq = 1; sa = m_res[s]; sd = m_rs2[s];
          if (!store_ready) break;
        end
        n++;
        if (m_err[s] != NOERR) break;
      end
    end
    obs_rc = int'(retire_count); obs_req = store_req; obs_addr = store_addr; obs_data = store_data;
    chk("retire_count", retire_count, n);
    chk("store_req", store_req, sreq);
    if (sreq) begin
      chk("store_addr", store_addr, sa);
      chk("store_data", store_data, sd);
    end
    for (int k = 0; k < RW; k++) begin
      e_cv[k] = (k < n);
      e_we[k] = m_we[sl[k]]; e_wi[k] = m_wi[sl[k]];
      e_wd[k] = m_res[sl[k]]; e_np[k] = m_npc[sl[k]];
      if (k < n) begin
        retm[sl[k]] = 1;
        if (m_err[sl[k]] != NOERR) begin m_halt = 1; m_stat = m_err[sl[k]]; end
      end
    end
    if (!clear_retire_buffer) begin
      for (int p = 0; p < CP; p++) begin
        if (cp_valid[p]) begin
          idx = int'(cp_rob_idx[p*5 +: 5]);
          for (int q = 0; q < p; q++)
            if (cp_valid[q] && int'(cp_rob_idx[q*5 +: 5]) == idx) dupn = 1;
          if (m_v[idx] && !retm[idx]) dupn = 1;
        end
      end
    end
    if (dupn) m_dup = 1;
    m_pci = n;
    @(posedge clock); #1;
    if (clear_retire_buffer) begin
      for (int i = 0; i < ROB; i++) m_v[i] = 0;
    end else begin
      for (int k = 0; k < n; k++) m_v[sl[k]] = 0;
      for (int p = CP - 1; p >= 0; p--) begin
        if (cp_valid[p]) begin
          idx = int'(cp_rob_idx[p*5 +: 5]);
          m_v[idx] = 1; m_st[idx] = cp_is_store[p]; m_we[idx] = cp_regfile_en[p];
          m_wi[idx] = cp_regfile_idx[p*6 +: 6]; m_res[idx] = cp_result[p*32 +: 32];
          m_rs2[idx] = cp_rs2_value[p*32 +: 32]; m_npc[idx] = cp_npc[p*32 +: 32];
          m_err[idx] = cp_error[p*4 +: 4];
        end
      end
    end
    for (int k = 0; k < RW; k++) begin
      hit = e_cv[k];
      chk("commit_valid", commit_valid[k], hit);
      if (hit) begin
        chk("commit_wr_en", commit_wr_en[k], e_we[k]);
        chk("commit_wr_idx", commit_wr_idx[k*6 +: 6], e_wi[k]);
        chk("commit_wr_data", commit_wr_data[k*32 +: 32], e_wd[k]);
        chk("commit_npc", commit_npc[k*32 +: 32], e_np[k]);
      end
    end
    chk("pipeline_completed_insts", pipeline_completed_insts, m_pci);
    chk("pipeline_error_status", pipeline_error_status, m_stat);
    chk("halted", halted, m_halt);
    chk("dup_error", dup_error, m_dup);
  endtask

  task automatic do_reset();
    @(negedge clock); #2;
    reset_n = 1'b0;
    idle();
    clear_retire_buffer = 1'b0;
    #1;
    model_reset();
    chk("rst_retire_count", retire_count, 0);
    chk("rst_store_req", store_req, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_wr_en", commit_wr_en, 0);
    chk("rst_commit_wr_data", commit_wr_data, 0);
    chk("rst_pci", pipeline_completed_insts, 0);
    chk("rst_status", pipeline_error_status, NOERR);
    chk("rst_halted", halted, 0);
    chk("rst_dup", dup_error, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int nret;
    do_reset();

    // two completions, then both retire together
    rob_head = 5'd0; store_ready = 1'b1;
    put(0, 5'd0, 32'h11, 32'h0, 0, 1, 6'd3, 32'h104, NOERR);
    put(1, 5'd1, 32'h22, 32'h0, 0, 1, 6'd4, 32'h108, NOERR);
    step();
    chk("t1_fill_rc", obs_rc, 0);
    idle();
    step();
    chk("t1_rc", obs_rc, 2);
    chk("t1_lane0_data", commit_wr_data[31:0], 32'h11);
    chk("t1_lane1_data", commit_wr_data[63:32], 32'h22);
    chk("t1_pci", pipeline_completed_insts, 2);

    // window wraps from slot 31 to slot 0
    rob_head = 5'd31;
    put(0, 5'd31, 32'h31, 32'h0, 0, 1, 6'd7, 32'h200, NOERR);
    put(1, 5'd0, 32'h30, 32'h0, 0, 1, 6'd8, 32'h204, NOERR);
    step();
    idle();
    step();
    chk("t2_wrap_rc", obs_rc, 2);
    step();
    chk("t2_cleared_rc", obs_rc, 0);

    // store at lane 0 stalls until the dcache accepts it
    rob_head = 5'd0;
    put(0, 5'd0, 32'h1000, 32'hDEAD, 1, 0, 6'd0, 32'h300, NOERR);
    put(1, 5'd1, 32'h33, 32'h0, 0, 1, 6'd9, 32'h304, NOERR);
    store_ready = 1'b0;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_stall_rc", obs_rc, 0);
      chk("t3_stall_req", obs_req, 1);
      chk("t3_addr", obs_addr, 32'h1000);
      chk("t3_data", obs_data, 32'hDEAD);
    end
    store_ready = 1'b1;
    step();
    chk("t3_go_rc", obs_rc, 2);

    // two stores back to back: one per cycle
    rob_head = 5'd2;
    put(0, 5'd2, 32'h2000, 32'hBEEF, 1, 0, 6'd0, 32'h400, NOERR);
    put(1, 5'd3, 32'h2004, 32'hCAFE, 1, 0, 6'd0, 32'h404, NOERR);
    step();
    idle();
    step();
    chk("t4_first_rc", obs_rc, 1);
    chk("t4_first_addr", obs_addr, 32'h2000);
    rob_head = 5'd3;
    step();
    chk("t4_second_req", obs_req, 1);
    chk("t4_second_addr", obs_addr, 32'h2004);
    chk("t4_second_rc", obs_rc, 1);

    // halting instruction commits as the last lane and freezes retirement
    rob_head = 5'd4;
    put(0, 5'd4, 32'h44, 32'h0, 0, 1, 6'd1, 32'h500, WFI);
    put(1, 5'd5, 32'h55, 32'h0, 0, 1, 6'd2, 32'h504, NOERR);
    step();
    idle();
    step();
    chk("t5_rc", obs_rc, 1);
    chk("t5_halted", halted, 1);
    chk("t5_status", pipeline_error_status, WFI);
    rob_head = 5'd5;
    step();
    chk("t5_after_rc", obs_rc, 0);

    // flush with four valid slots
    do_reset();
    rob_head = 5'd16;
    put(0, 5'd0, 32'h60, 32'h0, 0, 1, 6'd1, 32'h600, NOERR);
    put(1, 5'd1, 32'h61, 32'h0, 0, 1, 6'd2, 32'h604, NOERR);
    step();
    put(0, 5'd2, 32'h62, 32'h0, 0, 1, 6'd3, 32'h608, NOERR);
    put(1, 5'd3, 32'h63, 32'h0, 0, 1, 6'd4, 32'h60C, NOERR);
    step();
    idle();
    rob_head = 5'd0;
    clear_retire_buffer = 1'b1;
    step();
    chk("t6_flush_rc", obs_rc, 0);
    clear_retire_buffer = 1'b0;
    step();
    chk("t6_after_rc", obs_rc, 0);
    rob_head = 5'd2;
    step();
    chk("t6_after2_rc", obs_rc, 0);

    // randomized traffic, head follows the model's retire count
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      rob_head = 5'd0;
      for (int cyc = 0; cyc < 300; cyc++) begin
        idle();
        clear_retire_buffer = ($urandom % 40) == 0;
        store_ready = $urandom % 2;
        for (int p = 0; p < CP; p++) begin
          if (($urandom % 10) < 6)
            put(p, rob_head + 5'($urandom % 6), $urandom, $urandom, ($urandom % 4) == 0,
                $urandom % 2, 6'($urandom), $urandom,
                (($urandom % 80) == 0) ? ((($urandom % 2) == 0) ? ILL : WFI) : NOERR);
        end
        step();
        nret = obs_rc;
        rob_head = rob_head + 5'(nret);
      end
    end

    idle();
    clear_retire_buffer = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/retire_multi.md
Name: retire_multi

Overview:
- N-wide in-order retire stage with a per-ROB-slot completion buffer fed by several completion (CDB) ports.
- Each cycle it commits up to RETIRE_WIDTH consecutive completed entries starting at the ROB head, and reports the count to the ROB.
- It issues at most one store per cycle to the dcache through a valid/ready handshake.
- It stops permanently after a halting or illegal instruction commits.

Parameters:
- ROB_SZ, 32, buffer depth; power of two, >=4
- CP_PORTS, 2, number of completion ports
- RETIRE_WIDTH, 2, max commits per cycle; 1..4, <=ROB_SZ
- XLEN, 32, data width
- PREG_W, 6, physical/arch register index width
- IDX_W, $clog2(ROB_SZ), ROB index width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- cp_valid  in  CP_PORTS  completion valid per port
- cp_rob_idx  in  CP_PORTS*IDX_W  target slot
- cp_result  in  CP_PORTS*XLEN  result / store address
- cp_rs2_value  in  CP_PORTS*XLEN  store data
- cp_is_store  in  CP_PORTS  entry is a store
- cp_regfile_en  in  CP_PORTS  writes a register
- cp_regfile_idx  in  CP_PORTS*PREG_W  destination register
- cp_npc  in  CP_PORTS*XLEN  next PC
- cp_error  in  CP_PORTS*4  EXCEPTION_CODE (NO_ERROR/ILLEGAL_INST/HALTED_ON_WFI)
- rob_head  in  IDX_W  oldest ROB slot
- clear_retire_buffer  in  1  synchronous flush (mispredict)
- retire_count  out  $clog2(RETIRE_WIDTH+1)  entries committed this cycle (combinational)
- store_req  out  1  store request valid
- store_ready  in  1  dcache accepts store
- store_addr  out  XLEN  store address
- store_data  out  XLEN  store data
- commit_valid  out  RETIRE_WIDTH  registered per-lane commit strobe
- commit_wr_en  out  RETIRE_WIDTH  registered
- commit_wr_idx  out  RETIRE_WIDTH*PREG_W  registered
- commit_wr_data  out  RETIRE_WIDTH*XLEN  registered
- commit_npc  out  RETIRE_WIDTH*XLEN  registered
- pipeline_completed_insts  out  4  registered, equals prior retire_count
- pipeline_error_status  out  4  registered sticky EXCEPTION_CODE
- halted  out  1  sticky; set when an error entry commits
- dup_error  out  1  sticky; completion to an already-valid slot

Behaviour:
- Reset (reset_n=0, async):
  - All buffer valid bits 0.
  - All commit_* outputs 0, pipeline_completed_insts 0.
  - pipeline_error_status NO_ERROR; halted 0; dup_error 0.
  - store_req, retire_count 0.
- Completion write:
  - Each valid port writes its slot at the clock edge.
  - Without RETIRE_FWD_EN, an entry is eligible to retire the cycle after it is written (1-cycle latency).
  - Two ports targeting the same slot in one cycle: the lower port index wins, and dup_error is set.
  - A write to a slot already valid that is not being retired that cycle sets dup_error; the new data overwrites.
- Retire selection (combinational), lanes k=0..RETIRE_WIDTH-1, slot=(rob_head+k) mod ROB_SZ, wrapping at ROB_SZ-1 to 0. Lane k commits iff:
  - all lanes <k commit;
  - the slot is valid;
  - halted=0, clear_retire_buffer=0;
  - no earlier lane this cycle had an error;
  - if the slot is a store: it is the first store this cycle, and store_req&&store_ready.
- retire_count = number of lanes committing (contiguous from lane 0).
- Store handshake:
  - store_req=1 when the first non-committed-prefix lane holding a store is reachable (all earlier lanes commit). store_addr/store_data come from that entry.
  - store_req is held, with stable addr/data, until store_ready.
  - A store at lane 0 with store_ready=0 gives retire_count=0.
  - A store stalled at lane j>0 commits lanes 0..j-1 only.
- Edge updates: committed slots clear valid; the commit_* lanes register the committed data; unused lanes have commit_valid=0.
- Error commit: an entry with cp_error!=NO_ERROR commits as the last lane. pipeline_error_status latches its code, and halted=1. Thereafter retire_count=0 and store_req=0 until reset.
- Flush: clear_retire_buffer=1 clears all valids at the edge, forces retire_count=0 and store_req=0 that cycle, and ignores completions that cycle. halted and dup_error are unaffected.

Optional Feature:
- RETIRE_FWD_EN defined: a completion whose rob_idx equals a slot in the current lane window is bypassed into selection in the same cycle and, if committed, is not written into the buffer (0-cycle latency).
- Undefined: no bypass; 1-cycle latency as above.

Test Plan:
- Reset, then complete slots 0,1 (port0/port1) with head=0 → next cycle retire_count=2; commit_wr_data lanes = written values; pipeline_completed_insts=2 the following cycle.
- Head=31, slots 31 and 0 valid, RETIRE_WIDTH=2 → retire_count=2 (wrap); slots 31 and 0 valid cleared.
- Slot 0 is a store (addr 0x1000, data 0xDEAD), slot 1 is an ALU op, store_ready=0 for 3 cycles → store_req=1 with stable addr/data, retire_count=0. When store_ready=1 → retire_count=2.
- Slots 0 (store) and 1 (store) both valid, store_ready=1 → retire_count=1. Next cycle the second store is issued.
- Slot 0 has error HALTED_ON_WFI, slot 1 valid → retire_count=1, halted=1, pipeline_error_status=HALTED_ON_WFI. Subsequent retire_count=0.
- clear_retire_buffer with slots 0–3 valid → retire_count=0 that cycle, all valids 0 after the edge. With RETIRE_FWD_EN, a completion to head with an empty buffer → retire_count=1 in the same cycle.
